// File: rtl/facto_host_master.sv
// Bus initiator that drives a FactoCore slave through one factorial job.
// Optional FACTO_HOST_IRQ_EN: wait on the interrupt line instead of polling opdone.
module facto_host_master #(
    parameter logic [15:0] BASE_ADDR      = 16'h7000,
    parameter int unsigned POLL_GAP       = 8,
    parameter int unsigned TIMEOUT_CYCLES = 400000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_operand,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_result_h,
    output logic [63:0] rsp_result_l,
    output logic        rsp_error,
    output logic        m_sel,
    output logic        m_wr,
    output logic [15:0] m_addr,
    output logic [63:0] m_dout,
    input  logic [63:0] m_din,
    input  logic        interrupt
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_WR_OPERAND,
        S_WR_INTREN,
        S_WR_CLR0,
        S_WR_START,
        S_WAIT_DONE,
        S_RD_H,
        S_RD_L,
        S_WR_CLR1,
        S_WR_CLR_REL,
        S_RESP
    } state_t;

    localparam logic [31:0] LP_GAP = 32'(POLL_GAP);
    localparam logic [31:0] LP_TO  = 32'(TIMEOUT_CYCLES);

    state_t      r_state;
    logic        r_ph;
    logic [31:0] r_poll;
    logic [31:0] r_wait;
    logic [63:0] r_res_h;
    logic [63:0] r_res_l;
    logic        r_err;
    logic        r_sel;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [63:0] r_dout;

    state_t      w_nxt;
    logic        w_ph_nxt;
    logic [31:0] w_poll_nxt;
    logic [31:0] w_wait_nxt;
    logic        w_done;
    logic        w_tmo;
    logic        w_sel;
    logic        w_wr;
    logic [15:0] w_addr;
    logic [63:0] w_dout;

`ifndef FACTO_HOST_IRQ_EN
    logic w_unused_irq;
    assign w_unused_irq = interrupt;
`endif

    always_comb begin
        w_nxt      = r_state;
        w_ph_nxt   = 1'b0;
        w_poll_nxt = r_poll;
        w_wait_nxt = r_wait;
        w_tmo      = (LP_TO != 32'd0) && (r_wait == LP_TO - 32'd1);
`ifdef FACTO_HOST_IRQ_EN
        w_done     = interrupt;
`else
        // opdone data is valid at the end of the second poll-read cycle
        w_done     = (r_poll == LP_GAP + 32'd1) && m_din[0];
`endif
        unique case (r_state)
            S_IDLE:       if (req_valid) w_nxt = S_WR_OPERAND;
            S_WR_OPERAND: w_nxt = S_WR_INTREN;
            S_WR_INTREN:  w_nxt = S_WR_CLR0;
            S_WR_CLR0:    w_nxt = S_WR_START;
            S_WR_START: begin
                w_nxt      = S_WAIT_DONE;
                w_poll_nxt = 32'd0;
                w_wait_nxt = 32'd0;
            end
            S_WAIT_DONE: begin
                w_wait_nxt = r_wait + 32'd1;
                w_poll_nxt = (r_poll == LP_GAP + 32'd1) ? 32'd0
                                                        : r_poll + 32'd1;
                if (w_done)     w_nxt = S_RD_H;
                else if (w_tmo) w_nxt = S_WR_CLR1;
            end
            S_RD_H: begin
                if (!r_ph) w_ph_nxt = 1'b1;
                else       w_nxt    = S_RD_L;
            end
            S_RD_L: begin
                if (!r_ph) w_ph_nxt = 1'b1;
                else       w_nxt    = S_WR_CLR1;
            end
            S_WR_CLR1:    w_nxt = S_WR_CLR_REL;
            S_WR_CLR_REL: w_nxt = S_RESP;
            S_RESP:       if (rsp_ready) w_nxt = S_IDLE;
            default:      w_nxt = S_IDLE;
        endcase
    end

    // Bus outputs are computed for the state being entered, then registered
    always_comb begin
        w_sel  = 1'b0;
        w_wr   = 1'b0;
        w_addr = 16'h0000;
        w_dout = 64'd0;
        case (w_nxt)
            S_WR_OPERAND: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = BASE_ADDR + 16'h0020;
                w_dout = req_operand;
            end
            S_WR_INTREN: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = BASE_ADDR + 16'h0018;
`ifdef FACTO_HOST_IRQ_EN
                w_dout = 64'd1;
`else
                w_dout = 64'd0;
`endif
            end
            S_WR_CLR0, S_WR_CLR_REL: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = BASE_ADDR + 16'h0008;
            end
            S_WR_START: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_dout = 64'd1;
                w_addr = BASE_ADDR;
            end
            S_WR_CLR1: begin
                w_sel  = 1'b1;
                w_wr   = 1'b1;
                w_addr = BASE_ADDR + 16'h0008;
                w_dout = 64'd1;
            end
            S_WAIT_DONE: begin
`ifndef FACTO_HOST_IRQ_EN
                if (w_poll_nxt >= LP_GAP) begin
                    w_sel  = 1'b1;
                    w_addr = BASE_ADDR + 16'h0010;
                end
`endif
            end
            S_RD_H: begin
                w_sel  = 1'b1;
                w_addr = BASE_ADDR + 16'h0028;
            end
            S_RD_L: begin
                w_sel  = 1'b1;
                w_addr = BASE_ADDR + 16'h0030;
            end
            default: w_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_ph    <= 1'b0;
            r_poll  <= 32'd0;
            r_wait  <= 32'd0;
            r_res_h <= 64'd0;
            r_res_l <= 64'd0;
            r_err   <= 1'b0;
            r_sel   <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= 16'h0000;
            r_dout  <= 64'd0;
        end else begin
            r_state <= w_nxt;
            r_ph    <= w_ph_nxt;
            r_poll  <= w_poll_nxt;
            r_wait  <= w_wait_nxt;
            r_sel   <= w_sel;
            r_wr    <= w_wr;
            r_addr  <= w_addr;
            r_dout  <= w_dout;
            if (r_state == S_IDLE && req_valid) begin
                r_res_h <= 64'd0;
                r_res_l <= 64'd0;
                r_err   <= 1'b0;
            end
            if (r_state == S_WAIT_DONE && !w_done && w_tmo) r_err <= 1'b1;
            if (r_state == S_RD_H && r_ph) r_res_h <= m_din;
            if (r_state == S_RD_L && r_ph) r_res_l <= m_din;
        end
    end

    assign req_ready    = (r_state == S_IDLE);
    assign rsp_valid    = (r_state == S_RESP);
    assign rsp_result_h = r_res_h;
    assign rsp_result_l = r_res_l;
    assign rsp_error    = r_err;
    assign m_sel        = r_sel;
    assign m_wr         = r_wr;
    assign m_addr       = r_addr;
    assign m_dout       = r_dout;

endmodule

// File: tb/tb_facto_host_master.sv
// Directed bench for facto_host_master with a behavioural FactoCore slave.
// Built without FACTO_HOST_IRQ_EN, so done is found by polling opdone.
module tb_facto_host_master;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_operand = 64'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [63:0] rsp_result_h;
    logic [63:0] rsp_result_l;
    logic        rsp_error;
    logic        m_sel;
    logic        m_wr;
    logic [15:0] m_addr;
    logic [63:0] m_dout;
    logic [63:0] m_din = 64'd0;
    logic        interrupt = 1'b0;

    facto_host_master #(
        .BASE_ADDR(16'h7000),
        .POLL_GAP(8),
        .TIMEOUT_CYCLES(1000)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_operand(req_operand),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_result_h(rsp_result_h),
        .rsp_result_l(rsp_result_l),
        .rsp_error(rsp_error),
        .m_sel(m_sel),
        .m_wr(m_wr),
        .m_addr(m_addr),
        .m_dout(m_dout),
        .m_din(m_din),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // behavioural slave
    logic [63:0] s_operand = 64'd0;
    logic [63:0] s_rh = 64'd0;
    logic [63:0] s_rl = 64'd0;
    logic        s_done = 1'b0;
    logic        s_busy = 1'b0;
    int          s_cnt = 0;
    bit          nodone = 1'b0;

    function automatic logic [127:0] fact(input logic [63:0] n);
        logic [127:0] p;
        p = 128'd1;
        for (int i = 2; i <= int'(n); i++) p = p * 128'(i);
        return p;
    endfunction

    always @(posedge clk) begin
        if (m_sel && m_wr) begin
            if (m_addr == 16'h7020) s_operand <= m_dout;
            if (m_addr == 16'h7008 && m_dout[0]) begin
                s_done <= 1'b0;
                s_busy <= 1'b0;
                s_rh   <= 64'd0;
                s_rl   <= 64'd0;
            end
            if (m_addr == 16'h7000 && m_dout[0]) begin
                s_busy <= 1'b1;
                s_done <= 1'b0;
                s_cnt  <= 20 + int'(s_operand);
            end
        end else if (s_busy) begin
            if (s_cnt > 0) s_cnt <= s_cnt - 1;
            else if (!nodone) begin
                s_busy <= 1'b0;
                s_done <= 1'b1;
                {s_rh, s_rl} <= fact(s_operand);
            end
        end
        if (m_sel && !m_wr) begin
            case (m_addr)
                16'h7010: m_din <= {63'd0, s_done};
                16'h7028: m_din <= s_rh;
                16'h7030: m_din <= s_rl;
                default:  m_din <= 64'd0;
            endcase
        end
    end

    // bus monitor
    logic [15:0] wlog_addr[$];
    logic [63:0] wlog_data[$];
    int rd_res_cnt = 0;
    int poll_cnt = 0;
    int last_poll = -1;
    int poll_gap_seen = 0;
    int start_cyc = -1;
    bit prev_poll = 1'b0;

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_sel && m_wr) begin
                wlog_addr.push_back(m_addr);
                wlog_data.push_back(m_dout);
                if (m_addr == 16'h7000) start_cyc = cyc;
            end
            if (m_sel && !m_wr && (m_addr == 16'h7028 || m_addr == 16'h7030))
                rd_res_cnt++;
            if (m_sel && !m_wr && m_addr == 16'h7010 && !prev_poll) begin
                if (last_poll >= 0) poll_gap_seen = cyc - last_poll;
                last_poll = cyc;
                poll_cnt++;
            end
            prev_poll = m_sel && !m_wr && (m_addr == 16'h7010);
        end else begin
            prev_poll = 1'b0;
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_mon();
        wlog_addr.delete();
        wlog_data.delete();
        rd_res_cnt = 0;
        poll_cnt = 0;
        last_poll = -1;
        poll_gap_seen = 0;
        start_cyc = -1;
    endtask

    // Called right after a negedge; returns right after a negedge.
    task automatic do_req(input logic [63:0] op, input logic [63:0] eh,
                          input logic [63:0] el, input logic ee,
                          input int stall);
        int req_cyc;
        int n;
        logic [15:0] ea[6];
        logic [63:0] ed[6];
        ea = '{16'h7020, 16'h7018, 16'h7008, 16'h7000, 16'h7008, 16'h7008};
        ed = '{op, 64'd0, 64'd0, 64'd1, 64'd1, 64'd0};
        clear_mon();
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid = 1'b1;
        req_operand = op;
        req_cyc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) begin
            checks++;
            fails++;
            $display("FAIL rsp_wait: no rsp_valid for operand %0d", op);
            return;
        end
        chk("rsp_h", rsp_result_h, eh);
        chk("rsp_l", rsp_result_l, el);
        chk("rsp_err", 64'(rsp_error), 64'(ee));
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", 64'(rsp_valid), 64'd1);
            chk("stall_h", rsp_result_h, eh);
            chk("stall_l", rsp_result_l, el);
            chk("stall_req_ready", 64'(req_ready), 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_valid_drop", 64'(rsp_valid), 64'd0);
        chk("req_ready_after", 64'(req_ready), 64'd1);
        chk("wr_count", 64'(wlog_addr.size()), 64'd6);
        if (wlog_addr.size() == 6) begin
            for (int i = 0; i < 6; i++) begin
                chk("wr_addr", 64'(wlog_addr[i]), 64'(ea[i]));
                chk("wr_data", wlog_data[i], ed[i]);
            end
        end
        chk("res_reads", 64'(rd_res_cnt), ee ? 64'd0 : 64'd4);
        chk("start_latency", 64'(start_cyc - req_cyc), 64'd4);
        chk("poll_count_ge2", 64'(poll_cnt >= 2), 64'd1);
        chk("poll_spacing", 64'(poll_gap_seen), 64'd10);
    endtask

    typedef struct {
        logic [63:0] op;
        logic [63:0] h;
        logic [63:0] l;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int n;
        bit clr_seen;
        tbl[0] = '{64'd7,  64'd0, 64'd5040};
        tbl[1] = '{64'd0,  64'd0, 64'd1};
        tbl[2] = '{64'd1,  64'd0, 64'd1};
        tbl[3] = '{64'd21, 64'd2, 64'd14197454024290336768};
        tbl[4] = '{64'd20, 64'd0, 64'd2432902008176640000};
        tbl[5] = '{64'd10, 64'd0, 64'd3628800};

        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        chk("rst_m_sel", 64'(m_sel), 64'd0);
        chk("rst_m_wr", 64'(m_wr), 64'd0);
        chk("rst_m_addr", 64'(m_addr), 64'd0);
        chk("rst_m_dout", m_dout, 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_error", 64'(rsp_error), 64'd0);
        chk("rst_rsp_h", rsp_result_h, 64'd0);
        chk("rst_rsp_l", rsp_result_l, 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);

        // early rsp_ready outside RESP must not matter
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        for (int i = 0; i < 6; i++)
            do_req(tbl[i].op, tbl[i].h, tbl[i].l, 1'b0, 0);

        // reset while waiting for done
        clear_mon();
        req_valid = 1'b1;
        req_operand = 64'd6;
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (start_cyc < 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rst_mid_started", 64'(start_cyc >= 0), 64'd1);
        repeat (5) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        chk("rst_mid_m_sel", 64'(m_sel), 64'd0);
        chk("rst_mid_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_mid_req_ready", 64'(req_ready), 64'd1);
        clr_seen = 1'b0;
        foreach (wlog_addr[i])
            if (wlog_addr[i] == 16'h7008 && wlog_data[i] == 64'd1)
                clr_seen = 1'b1;
        chk("rst_mid_no_opclear", 64'(clr_seen), 64'd0);
        do_req(64'd5, 64'd0, 64'd120, 1'b0, 0);

        // slave never reports done
        nodone = 1'b1;
        do_req(64'd9, 64'd0, 64'd0, 1'b1, 0);
        nodone = 1'b0;

        // client holds off the response
        do_req(64'd3, 64'd0, 64'd6, 1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
